axil_master_initiator: RTL and testbench

- Single-outstanding AXI4-Lite master. It converts a simple command/response stream into AXI-Lite read and write transactions.
- It is the initiator end of the bus our accelerator wrapper exposes as a slave. It drives the CNN register window (5-bit decode) from an on-chip sequencer, or from the bench in place of the Vega core.
- One transaction is in flight at a time. The response returns on a valid/ready stream.

---
 rtl/axil_master_initiator_if.sv | 36 +++
 rtl/axil_master_initiator.sv | 189 ++++++++++++++++++
 tb/tb_axil_master_initiator.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_master_initiator_if.sv
// AXI4-Lite bus bundle between the command-stream initiator (master) and a register-window slave.
interface axil_master_initiator_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_master_initiator.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI-Lite transaction, one response out.
// Define AXIL_ERR_CNT_EN to add the saturating err_count output (non-OKAY B/R handshakes).
module axil_master_initiator #(
    parameter int ADDR_W = 32
`ifdef AXIL_ERR_CNT_EN
    ,
    parameter int ERR_CNT_W = 8
`endif
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
`ifdef AXIL_ERR_CNT_EN
    output logic [ERR_CNT_W-1:0]  err_count,
`endif
    axil_master_initiator_if.master m_axi
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              arvalid_q, arvalid_d;
    logic              bready_q, bready_d;
    logic              rready_q, rready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_write_q, rsp_write_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;

    assign cmd_ready       = (state_q == IDLE);
    assign rsp_valid       = rsp_valid_q;
    assign rsp_write       = rsp_write_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign rsp_resp        = rsp_resp_q;

    assign m_axi.awaddr    = addr_q;
    assign m_axi.awprot    = 3'b000;
    assign m_axi.awvalid   = awvalid_q;
    assign m_axi.wdata     = wdata_q;
    assign m_axi.wstrb     = wstrb_q;
    assign m_axi.wvalid    = wvalid_q;
    assign m_axi.bready    = bready_q;
    assign m_axi.araddr    = addr_q;
    assign m_axi.arprot    = 3'b000;
    assign m_axi.arvalid   = arvalid_q;
    assign m_axi.rready    = rready_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                // A cleared valid doubles as the done flag for its channel.
                if (m_axi.awready) awvalid_d = 1'b0;
                if (m_axi.wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axi.bvalid) begin
                    rsp_resp_d  = m_axi.bresp;
                    rsp_rdata_d = 32'h0;
                    rsp_write_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    bready_d    = 1'b0;
                    state_d     = RSP;
                end
            end
            RD_REQ: begin
                if (m_axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (m_axi.rvalid) begin
                    rsp_resp_d  = m_axi.rresp;
                    rsp_rdata_d = m_axi.rdata;
                    rsp_write_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    rready_d    = 1'b0;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

`ifdef AXIL_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 err_hit;

    // bready/rready are only high in their response states, so valid&ready is the handshake.
    always_comb begin
        err_hit   = (m_axi.bvalid && bready_q && (m_axi.bresp != 2'b00)) ||
                    (m_axi.rvalid && rready_q && (m_axi.rresp != 2'b00));
        err_cnt_d = err_cnt_q;
        if (err_hit && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) err_cnt_q <= '0;
        else                err_cnt_q <= err_cnt_d;
    end

    assign err_count = err_cnt_q;
`endif
endmodule

// File: tb/tb_axil_master_initiator.sv
// Randomized bench: bench-side AXI-Lite slave plus a transaction-level model of the expected bus/response behaviour.
module tb_axil_master_initiator;
    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_wdata;
    logic [3:0]        cmd_wstrb;
    logic              rsp_valid, rsp_ready, rsp_write;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_resp;
`ifdef AXIL_ERR_CNT_EN
    logic [7:0]        err_count;
`endif

    axil_master_initiator_if #(.ADDR_W(ADDR_W)) bus ();

    axil_master_initiator #(.ADDR_W(ADDR_W)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_write     (rsp_write),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
`ifdef AXIL_ERR_CNT_EN
        .err_count     (err_count),
`endif
        .m_axi         (bus)
    );

    typedef struct {
        bit        write;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [3:0]  wstrb;
    } cmd_t;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stimulus knobs: delay < 0 means random 0..3
    int aw_dly = -1, w_dly = -1, ar_dly = -1, b_dly = -1, r_dly = -1;
    int resp_mode = -1, rsp_rdy_mode = -1;
    bit fix_rd = 1'b0;
    bit [31:0] fix_rd_val = 32'h0;

    // Transaction-level model
    cmd_t cmd_q[$];
    cmd_t cur, c;
    bit   busy, aw_done, w_done, ar_done, got, cmd_taken;
    bit   exp_write;
    bit [31:0] exp_rdata;
    bit [1:0]  exp_resp, sl_resp;
    bit [31:0] sl_rdata;
    int   aw_w, w_w, ar_w, b_w, r_w;
    int   err_model;
    bit   e_aw, e_w, e_ar, e_b, e_r, e_rv, prev_rv;

    // Event log (cycle index of the edge after the negedge where the event is predicted)
    int cyc = 0, acc_cyc, aw_cyc, w_cyc, b_cyc, r_cyc, rsp_first_cyc, rsp_hs_cyc, rsp_cnt = 0;
    bit [31:0] last_awaddr, last_wdata, last_araddr, last_rdata;
    bit [3:0]  last_wstrb;
    bit        last_write;
    bit [1:0]  last_resp;

    function automatic int pick(input int k);
        return (k < 0) ? int'($urandom_range(0, 3)) : k;
    endfunction

    task automatic zero_slave();
        bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
        bus.bvalid = 1'b0; bus.bresp = 2'b00;
        bus.rvalid = 1'b0; bus.rresp = 2'b00; bus.rdata = 32'h0;
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0;
        zero_slave();
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                busy = 0; got = 0; cmd_taken = 0; prev_rv = 0; err_model = 0;
                cmd_valid = 1'b0; rsp_ready = 1'b0;
                zero_slave();
            end else begin
                e_aw = busy && cur.write && !aw_done;
                e_w  = busy && cur.write && !w_done;
                e_ar = busy && !cur.write && !ar_done;
                e_b  = busy && cur.write && aw_done && w_done && !got;
                e_r  = busy && !cur.write && ar_done && !got;
                e_rv = busy && got;
                // Compare every cycle
                chk("cmd_ready", cmd_ready, !busy);
                chk("awvalid", bus.awvalid, e_aw);
                chk("wvalid", bus.wvalid, e_w);
                chk("arvalid", bus.arvalid, e_ar);
                chk("bready", bus.bready, e_b);
                chk("rready", bus.rready, e_r);
                chk("rsp_valid", rsp_valid, e_rv);
                chk("prot", {bus.awprot, bus.arprot}, 6'b0);
                if (e_aw) chk("awaddr", bus.awaddr, cur.addr);
                if (e_w)  chk("wdata", {bus.wstrb, bus.wdata}, {cur.wstrb, cur.wdata});
                if (e_ar) chk("araddr", bus.araddr, cur.addr);
                if (e_rv) chk("rsp_fields", {rsp_write, rsp_resp, rsp_rdata}, {exp_write, exp_resp, exp_rdata});
`ifdef AXIL_ERR_CNT_EN
                chk("err_count", err_count, err_model);
`endif
                if (rsp_valid && !prev_rv) rsp_first_cyc = cyc;
                prev_rv = rsp_valid;

                // Drive command stream
                if (cmd_taken) begin cmd_valid = 1'b0; cmd_taken = 0; end
                if (!cmd_valid && cmd_q.size() > 0) begin
                    c = cmd_q.pop_front();
                    cmd_valid = 1'b1; cmd_write = c.write; cmd_addr = c.addr;
                    cmd_wdata = c.wdata; cmd_wstrb = c.wstrb;
                end
                // Drive slave
                bus.awready = 1'b0;
                if (bus.awvalid) begin if (aw_w == 0) bus.awready = 1'b1; else aw_w--; end
                bus.wready = 1'b0;
                if (bus.wvalid) begin if (w_w == 0) bus.wready = 1'b1; else w_w--; end
                bus.arready = 1'b0;
                if (bus.arvalid) begin if (ar_w == 0) bus.arready = 1'b1; else ar_w--; end
                bus.bvalid = 1'b0; bus.bresp = 2'($urandom);
                if (e_b) begin
                    if (b_w == 0) begin bus.bvalid = 1'b1; bus.bresp = sl_resp; end else b_w--;
                end
                bus.rvalid = 1'b0; bus.rresp = 2'($urandom); bus.rdata = $urandom;
                if (e_r) begin
                    if (r_w == 0) begin bus.rvalid = 1'b1; bus.rresp = sl_resp; bus.rdata = sl_rdata; end
                    else r_w--;
                end
                rsp_ready = (rsp_rdy_mode < 0) ? 1'($urandom) : 1'(rsp_rdy_mode);

                // Predict what happens at the coming edge
                if (cmd_valid && !busy && !cmd_taken) begin
                    busy = 1; cmd_taken = 1;
                    cur.write = cmd_write; cur.addr = cmd_addr; cur.wdata = cmd_wdata; cur.wstrb = cmd_wstrb;
                    aw_done = 0; w_done = 0; ar_done = 0; got = 0;
                    aw_w = pick(aw_dly); w_w = pick(w_dly); ar_w = pick(ar_dly);
                    b_w = pick(b_dly); r_w = pick(r_dly);
                    sl_resp = (resp_mode < 0) ? 2'($urandom) : 2'(resp_mode);
                    sl_rdata = fix_rd ? fix_rd_val : $urandom;
                    acc_cyc = cyc;
                end
                if (e_aw && bus.awready) begin aw_done = 1; aw_cyc = cyc; last_awaddr = bus.awaddr; end
                if (e_w && bus.wready) begin
                    w_done = 1; w_cyc = cyc; last_wdata = bus.wdata; last_wstrb = bus.wstrb;
                end
                if (e_ar && bus.arready) begin ar_done = 1; last_araddr = bus.araddr; end
                if (e_b && bus.bvalid) begin
                    got = 1; b_cyc = cyc; exp_write = 1; exp_rdata = 0; exp_resp = bus.bresp;
                    if (bus.bresp != 2'b00 && err_model < 255) err_model++;
                end
                if (e_r && bus.rvalid) begin
                    got = 1; r_cyc = cyc; exp_write = 0; exp_rdata = bus.rdata; exp_resp = bus.rresp;
                    if (bus.rresp != 2'b00 && err_model < 255) err_model++;
                end
                if (e_rv && rsp_ready) begin
                    busy = 0; got = 0; rsp_cnt++; rsp_hs_cyc = cyc;
                    last_write = rsp_write; last_resp = rsp_resp; last_rdata = rsp_rdata;
                end
            end
        end
    end

    task automatic push(input bit wr, input bit [31:0] a, input bit [31:0] d, input bit [3:0] s);
        cmd_t t;
        t.write = wr; t.addr = a; t.wdata = d; t.wstrb = s;
        cmd_q.push_back(t);
    endtask

    task automatic wait_rsp(input int n, input int budget);
        for (int i = 0; i < budget && rsp_cnt < n; i++) begin
            @(negedge clk); #2;
        end
        chk("rsp_count_reached", rsp_cnt >= n, 1'b1);
    endtask

    task automatic set_dly(input int a, input int w, input int ar, input int b, input int r);
        aw_dly = a; w_dly = w; ar_dly = ar; b_dly = b; r_dly = r;
    endtask

    int base, hs1;

    initial begin
        repeat (3) @(negedge clk);
        #2;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, rsp_valid}, 6'b0);
        chk("rst_rsp_fields", {rsp_write, rsp_resp, rsp_rdata}, 35'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifdef AXIL_ERR_CNT_EN
        set_dly(0, 0, 0, 0, 0); rsp_rdy_mode = 1;
        base = rsp_cnt; resp_mode = 2; push(1, 32'h0C, 32'h1, 4'hF); wait_rsp(base + 1, 50);
        chk("err_slverr_resp", last_resp, 2'b10);
        chk("err_count_1", err_count, 8'd1);
        base = rsp_cnt; resp_mode = 3; push(0, 32'h14, 32'h0, 4'h0); wait_rsp(base + 1, 50);
        chk("err_decerr_resp", last_resp, 2'b11);
        chk("err_count_2", err_count, 8'd2);
        base = rsp_cnt; resp_mode = 2;
        for (int i = 0; i < 300; i++) push(1, 32'h18, i, 4'hF);
        wait_rsp(base + 300, 300 * 10);
        chk("err_count_sat", err_count, 8'd255);
`endif

        // Write, slave always ready
        set_dly(0, 0, 0, 0, 0); rsp_rdy_mode = 1; resp_mode = 0;
        base = rsp_cnt; push(1, 32'h04, 32'hDEADBEEF, 4'hF); wait_rsp(base + 1, 50);
        chk("t1_aw_lat", aw_cyc - acc_cyc, 1);
        chk("t1_w_lat", w_cyc - acc_cyc, 1);
        chk("t1_b_lat", b_cyc - acc_cyc, 2);
        chk("t1_rsp_lat", rsp_first_cyc - acc_cyc, 3);
        chk("t1_awaddr", last_awaddr, 32'h04);
        chk("t1_wdata", {last_wstrb, last_wdata}, 36'hF_DEADBEEF);
        chk("t1_rsp", {last_write, last_resp, last_rdata}, {1'b1, 2'b00, 32'h0});

        // Split write: AW late, W immediate
        set_dly(3, 0, 0, 0, 0);
        base = rsp_cnt; push(1, 32'h08, 32'h12345678, 4'h3); wait_rsp(base + 1, 50);
        chk("t2_w_lat", w_cyc - acc_cyc, 1);
        chk("t2_aw_lat", aw_cyc - acc_cyc, 4);
        chk("t2_b_lat", b_cyc - acc_cyc, 5);
        repeat (4) @(negedge clk);
        #2 chk("t2_single_rsp", rsp_cnt, base + 1);

        // Read with 2-cycle rvalid delay
        set_dly(0, 0, 0, 0, 2); fix_rd = 1; fix_rd_val = 32'h0000_00A5;
        base = rsp_cnt; push(0, 32'h10, 32'h0, 4'h0); wait_rsp(base + 1, 50);
        chk("t3_araddr", last_araddr, 32'h10);
        chk("t3_r_lat", r_cyc - acc_cyc, 4);
        chk("t3_rsp", {last_write, last_resp, last_rdata}, {1'b0, 2'b00, 32'h0000_00A5});
        fix_rd = 0;

        // Response back-pressure with a queued command
        set_dly(0, 0, 0, 0, 0); rsp_rdy_mode = 0;
        base = rsp_cnt; push(1, 32'h1C, 32'hCAFEF00D, 4'hA); push(0, 32'h20, 32'h0, 4'h0);
        for (int i = 0; i < 50 && !rsp_valid; i++) begin @(negedge clk); #2; end
        chk("t4_rsp_seen", rsp_valid, 1'b1);
        repeat (5) @(negedge clk);
        #2 chk("t4_held_cmd_ready", cmd_ready, 1'b0);
        rsp_rdy_mode = 1;
        wait_rsp(base + 1, 50);
        hs1 = rsp_hs_cyc;
        wait_rsp(base + 2, 50);
        chk("t4_accept_after_rsp", acc_cyc - hs1, 1);

        // Reset during WR_REQ
        set_dly(6, 6, 0, 0, 0);
        push(1, 32'h24, 32'h55AA55AA, 4'hF);
        for (int i = 0; i < 20 && !bus.awvalid; i++) begin @(negedge clk); #2; end
        chk("t5_in_wr_req", bus.awvalid, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, rsp_valid}, 6'b0);
        chk("t5_async_cmd_ready", cmd_ready, 1'b1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("t5_post_cmd_ready", cmd_ready, 1'b1);
        chk("t5_post_rsp_valid", rsp_valid, 1'b0);

        // Randomized traffic
        set_dly(-1, -1, -1, -1, -1); resp_mode = -1; rsp_rdy_mode = -1;
        base = rsp_cnt;
        for (int i = 0; i < 150; i++) push(1'($urandom), $urandom, $urandom, 4'($urandom));
        wait_rsp(base + 150, 150 * 40);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
